max_q_select: RTL

Downstream stage of `target_net`. Consumes the serial stream of `NUMBER_OF_OUTPUT_NODE` IEEE-754 single-precision Q-values (`o_data`/`o_valid`) for one next-state evaluation and produces max Q(s',a') plus its action index. The result feeds the target-value computation (r + γ·maxQ). The block holds a running best value and index in registers, so no vector storage is needed.

---
 rtl/max_q_select.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/max_q_select.sv
// max_q_select
// Streams in one vector of FP32 Q-values (one element per i_valid, gaps
// allowed) and reports the maximum value and its 0-based arrival index.
// Only a running best value/index is held, so no vector storage is needed.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   i_data    - FP32 Q-value, sampled when i_valid = 1
//   i_valid   - one element per cycle it is high
//   o_max_q   - maximum Q of the last completed vector (bit-exact input copy)
//   o_action  - arrival index of o_max_q
//   o_nan     - 1 if any element of the last vector was NaN
//   o_valid   - one-cycle pulse when a new result is presented
//   o_busy    - 1 while a vector is partially received
module max_q_select #(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  parameter int INDEX_WIDTH           = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic [DATA_WIDTH-1:0]  o_max_q,
  output logic [INDEX_WIDTH-1:0] o_action,
  output logic                   o_nan,
  output logic                   o_valid,
  output logic                   o_busy
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t                 r_state;
  logic [INDEX_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0]  r_best;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic                   r_nan;
  logic [DATA_WIDTH-1:0]  r_max_q;
  logic [INDEX_WIDTH-1:0] r_action;
  logic                   r_out_nan;
  logic                   r_valid;
  logic                   r_busy;

  logic [DATA_WIDTH-1:0]  w_best_next;
  logic [INDEX_WIDTH-1:0] w_idx_next;
  logic                   w_nan_next;
  logic                   w_last;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
    is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Strict FP32 ordering on raw bits. A NaN candidate never wins; any
  // non-NaN candidate beats a NaN best so a NaN element 0 gets replaced.
  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    if (is_nan(a))
      greater = 1'b0;
    else if (is_nan(b))
      greater = 1'b1;
    else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
      greater = 1'b0;                  // +0 == -0
    else if (a[31] != b[31])
      greater = ~a[31];                // positive wins
    else if (!a[31])
      greater = (a[30:0] > b[30:0]);   // magnitude order for positives
    else
      greater = (a[30:0] < b[30:0]);   // reversed for negatives
  endfunction

  // Running best after folding in the current element.
  always_comb begin
    w_best_next = r_best;
    w_idx_next  = r_idx;
    w_nan_next  = r_nan | is_nan(i_data);
    if (r_state == S_IDLE) begin
      w_best_next = i_data;
      w_idx_next  = '0;
      w_nan_next  = is_nan(i_data);
    end else if (greater(i_data, r_best)) begin
      w_best_next = i_data;
      w_idx_next  = r_count;
    end
    // In IDLE count is 0, so a single-element vector completes immediately.
    w_last = (r_count == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_best    <= '0;
      r_idx     <= '0;
      r_nan     <= 1'b0;
      r_max_q   <= '0;
      r_action  <= '0;
      r_out_nan <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_COLLECT: begin
          if (i_valid) begin
            if (w_last) begin
              r_max_q   <= w_best_next;
              r_action  <= w_idx_next;
              r_out_nan <= w_nan_next;
              r_valid   <= 1'b1;
              r_count   <= '0;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_best  <= w_best_next;
              r_idx   <= w_idx_next;
              r_nan   <= w_nan_next;
              r_count <= r_count + 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_COLLECT;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_max_q  = r_max_q;
  assign o_action = r_action;
  assign o_nan    = r_out_nan;
  assign o_valid  = r_valid;
  assign o_busy   = r_busy;

endmodule
